// File: rtl/sound_isa_dma_ctrl.sv
// ISA DMA handshake controller: arbitrates the DSP 8/16-bit requests onto DRQ1/DRQ5 and runs
// single-cycle ISA DMA transfers, acking playback/record words back to the DSP.
module sound_isa_dma_ctrl #(
    parameter int TIMEOUT_US = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_1us,
    input  logic        dsp_req8,
    input  logic        dsp_req16,
    output logic        dsp_ack,
    output logic [15:0] dsp_readdata,
    input  logic [15:0] dsp_writedata,
    output logic        isa_drq1,
    output logic        isa_drq5,
    input  logic        isa_dack1_n,
    input  logic        isa_dack5_n,
    input  logic        isa_iow_n,
    input  logic        isa_ior_n,
    input  logic        isa_tc,
    input  logic [15:0] isa_d_in,
    output logic [15:0] isa_d_out,
    output logic        isa_d_oe,
    output logic        tc8,
    output logic        tc16,
    output logic        timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_US + 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_STB, XFER, DONE} state_t;

    // 8-bit transfers only carry the low byte; the high byte reads as zero.
    function automatic logic [15:0] lane_sel(input logic wide, input logic [15:0] w);
        return wide ? w : {8'h00, w[7:0]};
    endfunction

    // Async bundle order: {tc, ior_n, iow_n, dack5_n, dack1_n}; idle values are tc=0, strobes high.
    localparam logic [4:0] SYNC_IDLE = 5'b01111;

    logic [4:0]       sync_p0, sync_p1, sync_p2;
    logic [15:0]      d_in_p0;
    logic [15:0]      hold_q;
    state_t           state;
    logic             ch16, last_ch16, rec_q, tc_flag, done_dly;
    logic [CNT_W-1:0] to_cnt;

    logic dack1_s, dack5_s, iow_s, ior_s, tc_s;
    logic dack_s, stb_s, stb_rise, grant16;

    assign dack1_s  = sync_p1[0];
    assign dack5_s  = sync_p1[1];
    assign iow_s    = sync_p1[2];
    assign ior_s    = sync_p1[3];
    assign tc_s     = sync_p1[4];
    assign dack_s   = ch16 ? dack5_s : dack1_s;
    assign stb_s    = rec_q ? ior_s : iow_s;
    assign stb_rise = rec_q ? (ior_s & ~sync_p2[3]) : (iow_s & ~sync_p2[2]);
    // Round-robin: with both requesting, grant the channel that was not served last.
    assign grant16  = dsp_req16 & (~dsp_req8 | ~last_ch16);

    // Stage p0/p1: two-flop synchronisers; p2 keeps the previous synced value for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= SYNC_IDLE;
            sync_p1 <= SYNC_IDLE;
            sync_p2 <= SYNC_IDLE;
        end else begin
            sync_p0 <= {isa_tc, isa_ior_n, isa_iow_n, isa_dack5_n, isa_dack1_n};
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    // Data capture: bus input registered each clock, playback word held while IOW is low
    always_ff @(posedge clk) begin
        d_in_p0 <= isa_d_in;
        if (state == XFER && !rec_q && !iow_s)
            hold_q <= d_in_p0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ch16         <= 1'b0;
            last_ch16    <= 1'b1;
            rec_q        <= 1'b0;
            tc_flag      <= 1'b0;
            done_dly     <= 1'b0;
            to_cnt       <= '0;
            isa_drq1     <= 1'b0;
            isa_drq5     <= 1'b0;
            dsp_ack      <= 1'b0;
            dsp_readdata <= 16'h0000;
            isa_d_out    <= 16'h0000;
            isa_d_oe     <= 1'b0;
            tc8          <= 1'b0;
            tc16         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            dsp_ack <= 1'b0;
            tc8     <= 1'b0;
            tc16    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (dsp_req8 || dsp_req16) begin
                        ch16      <= grant16;
                        last_ch16 <= grant16;
                        isa_drq1  <= ~grant16;
                        isa_drq5  <= grant16;
                        to_cnt    <= '0;
                        tc_flag   <= 1'b0;
                        done_dly  <= 1'b0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (!dack_s) begin
                        isa_drq1 <= 1'b0;
                        isa_drq5 <= 1'b0;
                        state    <= WAIT_STB;
                    end else if (ce_1us) begin
                        if (to_cnt == CNT_W'(TIMEOUT_US - 1)) begin
                            isa_drq1 <= 1'b0;
                            isa_drq5 <= 1'b0;
                            timeout  <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                WAIT_STB: begin
                    // IOR takes priority when both strobes are seen low together.
                    if (!ior_s) begin
                        rec_q     <= 1'b1;
                        isa_d_oe  <= 1'b1;
                        isa_d_out <= lane_sel(ch16, dsp_writedata);
                        state     <= XFER;
                    end else if (!iow_s) begin
                        rec_q <= 1'b0;
                        state <= XFER;
                    end else if (dack_s) begin
                        state <= IDLE;
                    end
                end
                XFER: begin
                    if (!stb_s && tc_s)
                        tc_flag <= 1'b1;
                    if (stb_rise) begin
                        dsp_ack      <= 1'b1;
                        dsp_readdata <= rec_q ? 16'h0000 : lane_sel(ch16, hold_q);
                        tc8          <= tc_flag & ~ch16;
                        tc16         <= tc_flag & ch16;
                        isa_d_oe     <= 1'b0;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    // Extra clock after DACK release gives the DSP time to drop its request.
                    if (done_dly)
                        state <= IDLE;
                    else if (dack_s)
                        done_dly <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sound_isa_dma_ctrl.sv
// Directed bench for sound_isa_dma_ctrl: table of full DMA transfers plus timeout and
// reset-abort sequences.
module tb_sound_isa_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_1us = 1'b0;
    logic        dsp_req8 = 1'b0, dsp_req16 = 1'b0;
    logic        dsp_ack;
    logic [15:0] dsp_readdata;
    logic [15:0] dsp_writedata = 16'h0000;
    logic        isa_drq1, isa_drq5;
    logic        isa_dack1_n = 1'b1, isa_dack5_n = 1'b1;
    logic        isa_iow_n = 1'b1, isa_ior_n = 1'b1, isa_tc = 1'b0;
    logic [15:0] isa_d_in = 16'h0000;
    logic [15:0] isa_d_out;
    logic        isa_d_oe, tc8, tc16, timeout;

    sound_isa_dma_ctrl #(.TIMEOUT_US(8)) dut (
        .clk(clk), .rst(rst), .ce_1us(ce_1us),
        .dsp_req8(dsp_req8), .dsp_req16(dsp_req16),
        .dsp_ack(dsp_ack), .dsp_readdata(dsp_readdata), .dsp_writedata(dsp_writedata),
        .isa_drq1(isa_drq1), .isa_drq5(isa_drq5),
        .isa_dack1_n(isa_dack1_n), .isa_dack5_n(isa_dack5_n),
        .isa_iow_n(isa_iow_n), .isa_ior_n(isa_ior_n), .isa_tc(isa_tc),
        .isa_d_in(isa_d_in), .isa_d_out(isa_d_out), .isa_d_oe(isa_d_oe),
        .tc8(tc8), .tc16(tc16), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // ce_1us: one pulse every 3 clocks, changed on the falling edge.
    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            ce_1us = (div == 0);
            div = (div == 2) ? 0 : div + 1;
        end
    end

    int ack_cnt = 0, tc8_cnt = 0, tc16_cnt = 0, to_cnt = 0, drq1_hi = 0, drq5_hi = 0;
    logic [15:0] ack_rd = 16'h0;
    always @(negedge clk) begin
        if (dsp_ack) begin
            ack_cnt = ack_cnt + 1;
            ack_rd  = dsp_readdata;
        end
        if (tc8)      tc8_cnt  = tc8_cnt + 1;
        if (tc16)     tc16_cnt = tc16_cnt + 1;
        if (timeout)  to_cnt   = to_cnt + 1;
        if (isa_drq1) drq1_hi  = drq1_hi + 1;
        if (isa_drq5) drq5_hi  = drq5_hi + 1;
    end

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    // stb: 0 = IOW (play), 1 = IOR (record), 2 = both strobes together
    typedef struct {
        logic        rst;
        logic        req8, req16;
        logic [1:0]  stb;
        logic        tc;
        logic [15:0] din, wd;
        logic        ch16;
        logic [15:0] rd, dout;
        logic        t8, t16;
    } vec_t;

    vec_t vecs[7];

    task automatic run_row(input int idx, input vec_t v);
        int a0, t80, t160, d10, d50;
        logic got;
        bit rec;
        rec = (v.stb != 2'd0);
        if (v.rst) do_reset();
        a0 = ack_cnt; t80 = tc8_cnt; t160 = tc16_cnt; d10 = drq1_hi; d50 = drq5_hi;
        dsp_req8 = v.req8; dsp_req16 = v.req16; dsp_writedata = v.wd; isa_d_in = v.din;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (isa_drq1 || isa_drq5) got = 1'b1;
        end
        check($sformatf("row%0d_grant_seen", idx), got, 1);
        check($sformatf("row%0d_grant_ch16", idx), isa_drq5, v.ch16);
        tick(4);
        if (v.ch16) isa_dack5_n = 1'b0; else isa_dack1_n = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (!isa_drq1 && !isa_drq5) got = 1'b1;
        end
        check($sformatf("row%0d_drq_drop", idx), got, 1);
        isa_tc = v.tc;
        if (v.stb != 2'd0) isa_ior_n = 1'b0;
        if (v.stb != 2'd1) isa_iow_n = 1'b0;
        tick(5);
        check($sformatf("row%0d_oe_during", idx), isa_d_oe, rec);
        if (rec) check($sformatf("row%0d_dout", idx), isa_d_out, v.dout);
        isa_iow_n = 1'b1; isa_ior_n = 1'b1; isa_tc = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (ack_cnt != a0) got = 1'b1;
        end
        check($sformatf("row%0d_ack_seen", idx), got, 1);
        dsp_req8 = 1'b0; dsp_req16 = 1'b0;
        tick(3);
        check($sformatf("row%0d_oe_after", idx), isa_d_oe, 0);
        isa_dack1_n = 1'b1; isa_dack5_n = 1'b1;
        tick(6);
        check($sformatf("row%0d_ack_count", idx), ack_cnt - a0, 1);
        check($sformatf("row%0d_readdata", idx), ack_rd, v.rd);
        check($sformatf("row%0d_readdata_hold", idx), dsp_readdata, v.rd);
        check($sformatf("row%0d_tc8", idx), tc8_cnt - t80, v.t8);
        check($sformatf("row%0d_tc16", idx), tc16_cnt - t160, v.t16);
        check($sformatf("row%0d_other_drq", idx), v.ch16 ? (drq1_hi - d10) : (drq5_hi - d50), 0);
    endtask

    initial begin
        //         rst  r8   r16  stb   tc   din       wd        ch16 rd        dout      t8   t16
        vecs[0] = '{1'b0,1'b1,1'b0,2'd0,1'b0,16'hA55A,16'h0000,1'b0,16'h005A,16'h0000,1'b0,1'b0};
        vecs[1] = '{1'b0,1'b0,1'b1,2'd0,1'b1,16'h1234,16'h0000,1'b1,16'h1234,16'h0000,1'b0,1'b1};
        vecs[2] = '{1'b0,1'b0,1'b1,2'd1,1'b0,16'h0000,16'hBEEF,1'b1,16'h0000,16'hBEEF,1'b0,1'b0};
        vecs[3] = '{1'b0,1'b1,1'b0,2'd1,1'b0,16'h0000,16'hBEEF,1'b0,16'h0000,16'h00EF,1'b0,1'b0};
        vecs[4] = '{1'b1,1'b1,1'b1,2'd0,1'b0,16'h7788,16'h0000,1'b0,16'h0088,16'h0000,1'b0,1'b0};
        vecs[5] = '{1'b0,1'b1,1'b1,2'd2,1'b0,16'h1111,16'h5A5A,1'b1,16'h0000,16'h5A5A,1'b0,1'b0};
        vecs[6] = '{1'b0,1'b1,1'b1,2'd0,1'b1,16'hCAFE,16'h0000,1'b0,16'h00FE,16'h0000,1'b1,1'b0};

        rst = 1'b1;
        tick(3);
        check("reset_outputs",
              {dsp_ack, isa_drq1, isa_drq5, isa_d_oe, tc8, tc16, timeout}, 0);
        check("reset_readdata", dsp_readdata, 0);
        check("reset_dout", isa_d_out, 0);
        rst = 1'b0;
        tick(2);

        for (int r = 0; r < 7; r++) run_row(r, vecs[r]);

        // DACK never arrives: request abandoned after 8 ce_1us ticks, then re-armed.
        begin
            int ce_seen, t0;
            logic got;
            do_reset();
            t0 = to_cnt;
            dsp_req8 = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                tick();
                if (isa_drq1) got = 1'b1;
            end
            check("to_drq1_up", got, 1);
            ce_seen = 0;
            got = 1'b0;
            for (int i = 0; i < 200 && !got; i++) begin
                if (!isa_drq1) got = 1'b1;
                else begin
                    if (ce_1us) ce_seen = ce_seen + 1;
                    tick();
                end
            end
            check("to_drq1_dropped", got, 1);
            check("to_ce_ticks", ce_seen, 8);
            tick(1);
            check("to_pulse_count", to_cnt - t0, 1);
            got = 1'b0;
            for (int i = 0; i < 5 && !got; i++) begin
                tick();
                if (isa_drq1) got = 1'b1;
            end
            check("to_drq1_rearm", got, 1);
            dsp_req8 = 1'b0;
            do_reset();
        end

        // Reset while a record transfer is in XFER: everything drops, no ack for the cycle.
        begin
            int a0;
            logic got;
            a0 = ack_cnt;
            dsp_req16 = 1'b1; dsp_writedata = 16'h4321;
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                tick();
                if (isa_drq5) got = 1'b1;
            end
            check("rst_drq5_up", got, 1);
            isa_dack5_n = 1'b0;
            tick(5);
            isa_ior_n = 1'b0;
            tick(4);
            check("rst_oe_before", isa_d_oe, 1);
            rst = 1'b1;
            tick(1);
            check("rst_abort_outputs", {isa_drq1, isa_drq5, isa_d_oe, dsp_ack}, 0);
            rst = 1'b0;
            dsp_req16 = 1'b0;
            isa_ior_n = 1'b1; isa_dack5_n = 1'b1;
            tick(8);
            check("rst_no_ack", ack_cnt - a0, 0);
            dsp_req8 = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 5 && !got; i++) begin
                tick();
                if (isa_drq1) got = 1'b1;
            end
            check("rst_idle_regrant", got, 1);
            dsp_req8 = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
